// File: rtl/tape_stream_reader.sv
// ---------------------------------------------------------------------------
// tape_stream_reader
//   Streams a contiguous byte range out of the SDRAM tape read port into a
//   small first-word-fall-through FIFO and presents it to the tape playback
//   logic as a valid/ready byte stream. Only one SDRAM read is outstanding at
//   a time. A read is issued only when the FIFO is guaranteed a free entry
//   for its byte, so no returned byte is ever dropped.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start/start_addr/length  launch a transfer (ignored while busy)
//   abort                 cancel the current transfer
//   tape_addr/tape_rd     read request (rd is a one-cycle pulse)
//   tape_rd_ack/tape_rdata  toggle-style completion with its data byte
//   byte_valid/byte_data/byte_ready  FWFT byte stream to the consumer
//   busy/done/error       status: in progress, delivered pulse, sticky timeout
// ---------------------------------------------------------------------------
module tape_stream_reader #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic [ADDR_W-1:0] tape_addr,
  output logic              tape_rd,
  input  logic              tape_rd_ack,
  input  logic [7:0]        tape_rdata,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              ack_ref_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] req_left_q, req_left_d;
  logic [ADDR_W-1:0] out_left_q, out_left_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, cnt_next;

  logic              ack_seen;
  logic              pop;
  logic              push;
  logic              flush;
  logic              req_ok;
  logic              timed_out;

  // The responder toggles tape_rd_ack once per completed read. Tracking it
  // every cycle is equivalent to refreshing the reference only in IDLE and
  // on each detected change, and never leaves a stale edge behind.
  assign ack_seen  = (tape_rd_ack != ack_ref_q);
  assign pop       = (count_q != '0) && byte_ready;
  assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    out_left_d = out_left_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    push       = 1'b0;
    flush      = 1'b0;
    cnt_next   = count_q;
    req_ok     = 1'b0;

    if (pop && (out_left_q != '0)) begin
      out_left_d = out_left_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          error_d = 1'b0;
          if (length != '0) begin
            state_d    = S_REQ;
            busy_d     = 1'b1;
            addr_d     = start_addr;
            req_left_d = length;
            out_left_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        req_left_d = req_left_q - 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (ack_seen) begin
          push   = 1'b1;
          addr_d = addr_q + 1'b1;
        end else if (timed_out) begin
          error_d = 1'b1;
          flush   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        state_d = S_HOLD;
      end
      S_DRAIN: begin
        if (ack_seen || timed_out) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_next = count_q + CNT_W'(push) - CNT_W'(pop);

    // Credit: the next read's byte must have a slot once everything already
    // in flight (including the byte landing this cycle) is accounted for.
    req_ok = (req_left_q != '0) && (cnt_next < CNT_W'(FIFO_DEPTH));
    if ((state_q == S_WAIT && ack_seen) || state_q == S_HOLD) begin
      state_d = req_ok ? S_REQ : S_HOLD;
    end

    if (pop && (out_left_q == ADDR_W'(1)) &&
        (state_q inside {S_REQ, S_WAIT, S_HOLD})) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end

    // Abort wins over everything else. A read still in flight must have its
    // ack absorbed in DRAIN so it cannot be mistaken for a later transfer's.
    if (abort && (state_q != S_IDLE) && (state_q != S_DRAIN)) begin
      flush   = 1'b1;
      done_d  = 1'b0;
      error_d = error_q;
      if (state_q == S_WAIT && !ack_seen) begin
        state_d = S_DRAIN;
        busy_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ack_ref_q  <= 1'b0;
      addr_q     <= '0;
      req_left_q <= '0;
      out_left_q <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_ref_q  <= tape_rd_ack;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      out_left_q <= out_left_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= tape_rdata;
    end
  end

  assign tape_addr  = addr_q;
  assign tape_rd    = (state_q == S_REQ);
  assign byte_valid = (count_q != '0);
  // Gate the head so the data output reads 0 whenever the FIFO is empty.
  assign byte_data  = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_tape_stream_reader.sv
module tb_tape_stream_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [22:0] start_addr;
  logic [22:0] length;
  logic        abort;
  logic [22:0] tape_addr;
  logic        tape_rd;
  logic        tape_rd_ack;
  logic [7:0]  tape_rdata;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        error;

  tape_stream_reader #(
    .ADDR_W    (23),
    .FIFO_DEPTH(4),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .tape_addr  (tape_addr),
    .tape_rd    (tape_rd),
    .tape_rd_ack(tape_rd_ack),
    .tape_rdata (tape_rdata),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: SDRAM contents, expected request addresses and
  // expected delivered bytes.
  logic [7:0]  ov [int];
  logic [22:0] exp_addr [$];
  logic [7:0]  exp_q [$];

  int rd_count   = 0;
  int done_cnt   = 0;
  int ack_count  = 0;
  bit ack_en     = 1'b1;
  bit lat_rand   = 1'b0;
  int lat_fix    = 0;
  bit ready_mode = 1'b0;
  bit ready_val  = 1'b1;
  bit prev_rd    = 1'b0;

  function automatic logic [7:0] mem_at(input logic [22:0] a);
    if (ov.exists(int'(a))) return ov[int'(a)];
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory responder: acks by toggling on a clock edge after the request.
  initial begin
    logic [22:0] a;
    int l;
    forever begin
      @(negedge clk);
      if (reset_n && tape_rd && ack_en) begin
        a = tape_addr;
        l = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
        repeat (l) @(posedge clk);
        @(posedge clk);
        #1;
        tape_rdata  = mem_at(a);
        tape_rd_ack = ~tape_rd_ack;
        ack_count++;
      end
    end
  end

  // Consumer ready driver.
  initial begin
    byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: checks requests and delivered bytes against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (tape_rd) begin
          rd_count++;
          chk("rd_one_cycle", 32'(prev_rd), 32'd0);
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd actual=%0h required=none", tape_addr);
          end else begin
            chk("rd_addr", 32'(tape_addr), 32'(exp_addr.pop_front()));
          end
        end
        prev_rd = tape_rd;
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", byte_data);
          end else begin
            chk("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_with_done", 32'(busy), 32'd0);
        end
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  // mode 0: full transfer expected; mode 1: only the first request expected.
  task automatic do_start(input logic [22:0] a, input logic [22:0] n, input int mode);
    logic [22:0] ai;
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    length     = n;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + 23'(i);
      if (mode == 0 || i == 0) exp_addr.push_back(ai);
      if (mode == 0) exp_q.push_back(mem_at(ai));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_rd(input string name, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tape_rd) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, a0, k;
    logic [22:0] ra, rl;
    reset_n     = 1'b0;
    start       = 1'b0;
    start_addr  = '0;
    length      = '0;
    abort       = 1'b0;
    tape_rd_ack = 1'b0;
    tape_rdata  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {tape_addr, tape_rd, byte_valid, byte_data, busy, done, error}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset asserted while waiting for an ack.
    ack_en = 1'b0;
    do_start(23'h000100, 23'd3, 1);
    wait_rd("t1_rd", 10);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_reset_async", {tape_addr, tape_rd, byte_valid, byte_data, busy, done, error}, 32'd0);
    exp_addr.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ack_en  = 1'b1;

    // Basic 5-byte transfer.
    for (int i = 0; i < 5; i++) ov[32'h1000 + i] = 8'(11 + i);
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    r0 = rd_count;
    d0 = done_cnt;
    do_start(23'h001000, 23'd5, 0);
    wait_done("t2_done", 100);
    repeat (3) @(posedge clk);
    chk("t2_rd_count", 32'(rd_count - r0), 32'd5);
    chk("t2_all_bytes", 32'(exp_q.size()), 32'd0);
    chk("t2_one_done", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    chk("t2_busy_low", 32'(busy), 32'd0);

    // Back-pressure: FIFO credit limits outstanding reads.
    ready_val = 1'b0;
    @(posedge clk);
    r0 = rd_count;
    do_start(23'h001234, 23'd10, 0);
    repeat (40) @(posedge clk);
    chk("t3_rd_stalled", 32'(rd_count - r0), 32'd4);
    @(negedge clk);
    chk("t3_valid_held", 32'(byte_valid), 32'd1);
    chk("t3_busy_held", 32'(busy), 32'd1);
    ready_val = 1'b1;
    wait_done("t3_done", 200);
    chk("t3_rd_total", 32'(rd_count - r0), 32'd10);
    chk("t3_all_bytes", 32'(exp_q.size()), 32'd0);

    // Zero-length transfer.
    r0 = rd_count;
    d0 = done_cnt;
    do_start(23'h0001F0, 23'd0, 0);
    @(negedge clk);
    chk("t4_done_next", 32'(done), 32'd1);
    chk("t4_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_done_pulse", 32'(done), 32'd0);
    @(posedge clk);
    chk("t4_no_rd", 32'(rd_count - r0), 32'd0);
    chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Abort while a read is in flight.
    lat_fix = 6;
    do_start(23'h003000, 23'd3, 0);
    wait_rd("t5_rd", 10);
    d0 = done_cnt;
    a0 = ack_count;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_drain", 32'(busy), 32'd1);
    chk("t5_valid_low", 32'(byte_valid), 32'd0);
    exp_addr.delete();
    exp_q.delete();
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      @(negedge clk);
      k++;
    end
    chk("t5_busy_falls", 32'(busy), 32'd0);
    chk("t5_waited_ack", 32'(ack_count - a0), 32'd1);
    repeat (3) @(posedge clk);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    lat_fix = 0;
    do_start(23'h002000, 23'd1, 0);
    wait_done("t5_restart_done", 50);
    chk("t5_restart_bytes", 32'(exp_q.size()), 32'd0);

    // Ack timeout.
    ack_en = 1'b0;
    do_start(23'h004000, 23'd2, 1);
    wait_rd("t6_rd", 10);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (error) break;
    end
    chk("t6_timeout_cycles", 32'((k >= 16) && (k <= 17)), 32'd1);
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_busy_low", 32'(busy), 32'd0);
    chk("t6_fifo_empty", 32'(byte_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_error_sticky", 32'(error), 32'd1);
    exp_addr.delete();
    ack_en = 1'b1;
    do_start(23'h005000, 23'd1, 0);
    @(negedge clk);
    chk("t6_error_cleared", 32'(error), 32'd0);
    wait_done("t6_restart_done", 50);

    // Address wrap.
    r0 = rd_count;
    do_start(23'h7FFFFF, 23'd2, 0);
    wait_done("t7_done", 50);
    chk("t7_rd_count", 32'(rd_count - r0), 32'd2);
    chk("t7_addr_all", 32'(exp_addr.size()), 32'd0);

    // Randomized transfers with random latency and back-pressure.
    ready_mode = 1'b1;
    lat_rand   = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ra = 23'($urandom);
      rl = 23'($urandom_range(1, 12));
      do_start(ra, rl, 0);
      wait_done("rnd_done", 600);
      chk("rnd_bytes_left", 32'(exp_q.size()), 32'd0);
      chk("rnd_addr_left", 32'(exp_addr.size()), 32'd0);
    end
    @(negedge clk);
    chk("rnd_no_error", 32'(error), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
